// File: rtl/cpu_pkg.sv
// Shared CPU definitions: machine width, NOP encoding, default reset PC,
// IF/ID pipeline register payload and the fetch-stage fault FSM states.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INS          = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // IF/ID payload, also consumed by the datapath decode stage
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] ins;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } if_id_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

   // True when an address points at a 32-bit word boundary
   function automatic logic word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble has priority over load; with neither the
// register holds. A bubble clears valid and forces the NOP word so decode
// never sees a stale instruction next to valid=0.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t q_r;

   // Pipeline register with async reset to a NOP bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r.valid    <= 1'b0;
         q_r.ins      <= NOP_INS;
         q_r.pc       <= {XLEN{1'b0}};
         q_r.pc_plus4 <= {XLEN{1'b0}};
      end else if (bubble) begin
         q_r.valid <= 1'b0;
         q_r.ins   <= NOP_INS;
      end else if (load) begin
         q_r <= d;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to the combinational
// icache, and registers the returned word into IF/ID. Redirects win over
// stalls; a misaligned redirect or an out-of-range fetch parks the stage in
// a sticky FAULT state that only reset leaves.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          ICACHE_SIZE = 128
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pc,
   input  logic [31:0] ins,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   output logic [31:0] id_ins,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);

   // Low bits forced to zero so the PC is word aligned even if misconfigured
   localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
   localparam logic [XLEN-3:0] ICACHE_WORDS     = (XLEN-2)'(ICACHE_SIZE);

   fetch_state_e    state_r, state_next_s;
   logic [XLEN-1:0] pc_r, pc_next_s, pc_plus4_s;
   logic [XLEN-1:0] fault_pc_r, fault_addr_s;
   logic [XLEN-1:0] count_r;
   logic            misaligned_s, out_of_range_s;
   logic            id_load_s, id_bubble_s, count_inc_s, fault_set_s;
   if_id_t          id_d_s, id_q_s;

   assign pc_plus4_s     = pc_r + 32'd4;
   assign misaligned_s   = !word_aligned(redirect_target);
   assign out_of_range_s = (pc_r[XLEN-1:2] >= ICACHE_WORDS);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state: enter FAULT on a bad redirect or an out-of-range fetch
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         RUN: begin
            if (redirect_valid) begin
               state_next_s = misaligned_s ? FAULT : RUN;
            end else if (stall) begin
               state_next_s = RUN;
            end else if (out_of_range_s) begin
               state_next_s = FAULT;
            end else begin
               state_next_s = RUN;
            end
         end
         FAULT:   state_next_s = FAULT;
         default: state_next_s = FAULT;
      endcase
   end

   // FSM outputs: PC update, IF/ID control, counter and fault capture
   always_comb begin
      pc_next_s    = pc_r;
      id_load_s    = 1'b0;
      id_bubble_s  = 1'b0;
      count_inc_s  = 1'b0;
      fault_set_s  = 1'b0;
      fault_addr_s = fault_pc_r;
      case (state_r)
         RUN: begin
            if (redirect_valid) begin
               id_bubble_s = 1'b1;
               if (misaligned_s) begin
                  fault_set_s  = 1'b1;
                  fault_addr_s = redirect_target;
               end else begin
                  pc_next_s = redirect_target;
               end
            end else if (stall) begin
               pc_next_s = pc_r;
            end else if (out_of_range_s) begin
               id_bubble_s  = 1'b1;
               fault_set_s  = 1'b1;
               fault_addr_s = pc_r;
            end else begin
               pc_next_s   = pc_plus4_s;
               id_load_s   = 1'b1;
               count_inc_s = 1'b1;
            end
         end
         FAULT:   id_bubble_s = 1'b1;
         default: id_bubble_s = 1'b1;
      endcase
   end

   // PC, fault address and delivered-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= RESET_PC_ALIGNED;
         fault_pc_r <= {XLEN{1'b0}};
         count_r    <= {XLEN{1'b0}};
      end else begin
         pc_r       <= pc_next_s;
         fault_pc_r <= fault_set_s ? fault_addr_s : fault_pc_r;
         count_r    <= count_inc_s ? (count_r + 32'd1) : count_r;
      end
   end

   assign id_d_s.valid    = 1'b1;
   assign id_d_s.ins      = ins;
   assign id_d_s.pc       = pc_r;
   assign id_d_s.pc_plus4 = pc_plus4_s;

   if_id_reg u_if_id (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (id_load_s),
      .bubble (id_bubble_s),
      .d      (id_d_s),
      .q      (id_q_s)
   );

   assign pc          = pc_r;
   assign id_valid    = id_q_s.valid;
   assign id_ins      = id_q_s.ins;
   assign id_pc       = id_q_s.pc;
   assign id_pc_plus4 = id_q_s.pc_plus4;
   assign fetch_fault = (state_r == FAULT);
   assign fault_pc    = fault_pc_r;
   assign fetch_count = count_r;

endmodule
